load_store_unit: RTL and testbench

- Memory-stage block directly downstream of the ALU. It takes the ALU result (`operand1` + immediate) as the effective address for RV32I loads and stores.
- Runs one data-memory transaction per request over a req/ready bus: lane steering and byte strobes for stores, byte/halfword extraction and sign/zero extension for loads.
- Reports misaligned addresses and bus timeouts to the control unit as completion status.

---
 rtl/load_store_unit_if.sv | 12 +
 rtl/load_store_unit.sv | 101 ++++++++++
 tb/tb_load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory req/ready bus between the load/store unit and memory.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    modport master(output req, we, addr, wdata, wstrb, input rdata, ready);
    modport slave(input req, we, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage; one bus access per request with lane steering,
// load extension, misalignment and timeout reporting.
module load_store_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              store_data,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              load_data,
    output logic                     misaligned,
    output logic                     access_fault,
    load_store_unit_if.master        mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
    state_t      state;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        st_r;
    logic [7:0]  cnt;
    logic        illegal, mis;
    logic [31:0] wdata_n, ld_n;
    logic [3:0]  wstrb_n;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        illegal = is_store ? (funct3 >= 3'b011) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        mis     = funct3[1:0] == 2'b01 ? addr[0] : funct3[1:0] == 2'b10 ? |addr[1:0] : 1'b0;
        wdata_n = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
        wstrb_n = !is_store ? 4'b0000 :
                  funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                  funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        byte_v  = mem.rdata[{off_r, 3'b000} +: 8];
        half_v  = mem.rdata[{off_r[1], 4'b0000} +: 16];
        ld_n    = f3_r == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                  f3_r == 3'b001 ? {{16{half_v[15]}}, half_v} :
                  f3_r == 3'b100 ? {24'd0, byte_v} :
                  f3_r == 3'b101 ? {16'd0, half_v} : mem.rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            load_data    <= 32'd0;
            mem.req      <= 1'b0;
            mem.we       <= 1'b0;
            mem.addr     <= 32'd0;
            mem.wdata    <= 32'd0;
            mem.wstrb    <= 4'd0;
            cnt          <= 8'd0;
            f3_r         <= 3'd0;
            off_r        <= 2'd0;
            st_r         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    st_r         <= is_store;
                    f3_r         <= funct3;
                    off_r        <= addr[1:0];
                    busy         <= 1'b1;
                    cnt          <= 8'd0;
                    mem.addr     <= {addr[31:2], 2'b00};
                    mem.wdata    <= wdata_n;
                    mem.wstrb    <= wstrb_n;
                    access_fault <= illegal;
                    misaligned   <= !illegal && mis;
                    // Faults detected here complete without touching the bus.
                    mem.req      <= !(illegal || mis);
                    mem.we       <= is_store && !(illegal || mis);
                    done         <= illegal || mis;
                    state        <= (illegal || mis) ? RESP : ACCESS;
                end
                ACCESS: if (mem.ready || cnt == LAST) begin
                    mem.req      <= 1'b0;
                    mem.we       <= 1'b0;
                    done         <= 1'b1;
                    access_fault <= !mem.ready;
                    state        <= RESP;
                    if (mem.ready && !st_r) load_data <= ld_n;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with MAX_WAIT=4.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        busy, done, misaligned, access_fault;
    logic [31:0] load_data;
    int checks = 0;
    int failures = 0;
    typedef struct packed {
        logic [31:0] ld;
        logic        mis;
        logic        af;
    } exp_t;
    exp_t q[$];
    load_store_unit_if mem();
    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .load_data(load_data), .misaligned(misaligned), .access_fault(access_fault),
        .mem(mem)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // One request; ready_at = req cycle in which mem_ready is given (0 = never).
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int ready_at, input int lat, input int nreq,
                       input logic [3:0] strb, input logic [31:0] wd,
                       input logic [31:0] xld, input logic xmis, input logic xaf);
        exp_t e;
        int k = 0;
        int reqs = 0;
        bit got = 0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem.rdata = rd; mem.ready = 1'b0;
        q.push_back({xld, xmis, xaf});
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            mem.ready = 1'b0;
            if (mem.req) begin
                reqs++;
                if (reqs == 1) begin
                    chk({tag, ".addr"}, mem.addr, {a[31:2], 2'b00});
                    chk({tag, ".we"}, mem.we, st);
                    chk({tag, ".wstrb"}, mem.wstrb, strb);
                    if (st) chk({tag, ".wdata"}, mem.wdata, wd);
                end
                mem.ready = (reqs == ready_at);
            end
            if (done) begin
                got = 1;
                e = q.pop_front();
                chk({tag, ".load_data"}, load_data, e.ld);
                chk({tag, ".misaligned"}, misaligned, e.mis);
                chk({tag, ".access_fault"}, access_fault, e.af);
                chk({tag, ".latency"}, k, lat);
                chk({tag, ".req_cycles"}, reqs, nreq);
                chk({tag, ".req_at_done"}, mem.req, 1'b0);
            end
        end
        if (!got) chk({tag, ".done_timeout"}, 1'b0, 1'b1);
        mem.ready = 1'b0;
    endtask
    initial begin
        mem.rdata = 32'd0;
        mem.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.load_data", load_data, 32'd0);
        chk("rst.req", mem.req, 1'b0);
        chk("rst.wstrb", mem.wstrb, 4'd0);
        chk("rst.addr", mem.addr, 32'd0);
        rst = 1'b0;
        run("sw",  1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 2, 1, 4'b1111, 32'hDEADBEEF, 32'd0, 0, 0);
        run("sb",  1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 2, 1, 4'b1000, 32'hA5A5A5A5, 32'd0, 0, 0);
        run("sh",  1, 3'b001, 32'h102, 32'h00001234, 0, 1, 2, 1, 4'b1100, 32'h12341234, 32'd0, 0, 0);
        run("lb1", 0, 3'b000, 32'h201, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'h0000007F, 0, 0);
        run("lbu3",0, 3'b100, 32'h203, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'h00000080, 0, 0);
        run("lb3", 0, 3'b000, 32'h203, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'hFFFFFF80, 0, 0);
        run("lh2", 0, 3'b001, 32'h202, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'hFFFF80FF, 0, 0);
        run("lhu2",0, 3'b101, 32'h202, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'h000080FF, 0, 0);
        run("lw",  0, 3'b010, 32'h200, 0, 32'h80FF7F01, 1, 2, 1, 4'b0000, 0, 32'h80FF7F01, 0, 0);
        run("lw_mis", 0, 3'b010, 32'h102, 0, 32'h0, 1, 1, 0, 4'b0000, 0, 32'h80FF7F01, 1, 0);
        run("lh_mis", 0, 3'b001, 32'h201, 0, 32'h0, 1, 1, 0, 4'b0000, 0, 32'h80FF7F01, 1, 0);
        run("ld_f3",  0, 3'b011, 32'h200, 0, 32'h0, 1, 1, 0, 4'b0000, 0, 32'h80FF7F01, 0, 1);
        run("st_both",1, 3'b100, 32'h101, 0, 32'h0, 1, 1, 0, 4'b0000, 0, 32'h80FF7F01, 0, 1);
        run("timeout",0, 3'b010, 32'h300, 0, 32'h11223344, 0, 5, 4, 4'b0000, 0, 32'h80FF7F01, 0, 1);
        run("last_ok",0, 3'b010, 32'h300, 0, 32'h11223344, 4, 5, 4, 4'b0000, 0, 32'h11223344, 0, 0);
        run("sb_keep",1, 3'b000, 32'h001, 32'h5A, 0, 2, 3, 2, 4'b0010, 32'h5A5A5A5A, 32'h11223344, 0, 0);
        // Second start while in RESP must not launch another access.
        run("sw2", 1, 3'b010, 32'h104, 32'h01020304, 0, 1, 2, 1, 4'b1111, 32'h01020304, 32'h11223344, 0, 0);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        start = 1'b0;
        chk("resp_start.req", mem.req, 1'b0);
        chk("resp_start.busy", busy, 1'b0);
        chk("resp_start.done", done, 1'b0);
        @(negedge clk);
        chk("resp_start.req2", mem.req, 1'b0);
        // Reset while the bus request is outstanding.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("rst_mid.req_before", mem.req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.req", mem.req, 1'b0);
        chk("rst_mid.busy", busy, 1'b0);
        chk("rst_mid.done", done, 1'b0);
        chk("rst_mid.load_data", load_data, 32'd0);
        @(negedge clk);
        chk("rst_mid.done2", done, 1'b0);
        chk("rst_mid.busy2", busy, 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
